// File: rtl/dep_tracker_if.sv
// Purpose: handshake and status bundle between a dispatch front end and dep_tracker.
// Latency: wires only; timing is set by dep_tracker (alloc_ready combinational, status registered).
// Backpressure: alloc_valid is honoured only while alloc_ready is high; retire is never stalled.
interface dep_tracker_if #(
    parameter int REGNUM = 32,
    parameter int BS     = 16,
    parameter int NSRC   = 2
);
    localparam int IW = $clog2(BS);
    localparam int RW = $clog2(REGNUM);

    logic                 alloc_valid;
    logic                 alloc_ready;
    logic [IW-1:0]        alloc_idx;
    logic [NSRC*RW-1:0]   rs;
    logic [NSRC-1:0]      rs_use;
    logic [RW-1:0]        rd;
    logic                 rd_we;
    logic                 ret_valid;
    logic [IW-1:0]        ret_idx;
    logic [BS-1:0]        idt;
    logic                 idt_valid;
    logic [BS-1:0]        entry_valid;
    logic [BS-1:0]        issue_rdy;

    // Front end: issues inserts/retires, observes status.
    modport master (
        output alloc_valid, alloc_idx, rs, rs_use, rd, rd_we, ret_valid, ret_idx,
        input  alloc_ready, idt, idt_valid, entry_valid, issue_rdy
    );

    // Tracker side.
    modport slave (
        input  alloc_valid, alloc_idx, rs, rs_use, rd, rd_we, ret_valid, ret_idx,
        output alloc_ready, idt, idt_valid, entry_valid, issue_rdy
    );
endinterface

// File: rtl/dep_tracker.sv
// Purpose: matrix-based register dependency tracker; optional WAR/WAW tracking via DEP_TRACKER_NAMEDEP_EN.
// Latency: idt/idt_valid/entry_valid/issue_rdy update one clock after the causing insert/retire.
// Backpressure: alloc_ready drops while the target column is occupied (unless retired the same cycle).
module dep_tracker #(
    parameter int REGNUM = 32,
    parameter int BS     = 16,
    parameter int NSRC   = 2
) (
    input  logic          clk,
    input  logic          rst,
    dep_tracker_if.slave  bus
);
    localparam int IW = $clog2(BS);
    localparam int RW = $clog2(REGNUM);

    // Producer matrix: rd_m[r][e] = entry e writes register r.
    logic [BS-1:0] rd_m     [REGNUM];
    logic [BS-1:0] rd_nxt   [REGNUM];
`ifdef DEP_TRACKER_NAMEDEP_EN
    // Reader matrix: rs_m[r][e] = entry e reads register r. Only name
    // dependencies consume it, so it exists only in that build.
    logic [BS-1:0] rs_m     [REGNUM];
    logic [BS-1:0] rs_nxt   [REGNUM];
`endif
    // Wait matrix: wait_m[w][p] = waiter w depends on producer p.
    logic [BS-1:0] wait_m   [BS];
    logic [BS-1:0] wait_nxt [BS];

    logic [BS-1:0] valid_q;
    logic [BS-1:0] valid_nxt;
    logic [BS-1:0] valid_ret;
    logic [BS-1:0] dep;
    logic [BS-1:0] issue_nxt;
    logic [BS-1:0] idt_q;
    logic          idt_valid_q;
    logic [BS-1:0] issue_rdy_q;
    logic          ins;

    // A column may be reused in the cycle it is being freed.
    assign bus.alloc_ready = ~valid_q[bus.alloc_idx] |
                             (bus.ret_valid && (bus.ret_idx == bus.alloc_idx));
    assign ins             = bus.alloc_valid & bus.alloc_ready;

    assign bus.idt         = idt_q;
    assign bus.idt_valid   = idt_valid_q;
    assign bus.entry_valid = valid_q;
    assign bus.issue_rdy   = issue_rdy_q;

    // Occupancy as seen after this cycle's retire; dependencies are formed against it.
    always_comb begin
        valid_ret = valid_q;
        if (bus.ret_valid)
            valid_ret[bus.ret_idx] = 1'b0;
    end

    // Dependency vector of the incoming instruction (register 0 never matches).
    always_comb begin
        dep = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (bus.rs_use[k] && (bus.rs[k*RW +: RW] != '0))
                dep = dep | rd_m[bus.rs[k*RW +: RW]];
        end
`ifdef DEP_TRACKER_NAMEDEP_EN
        if (bus.rd_we && (bus.rd != '0))
            dep = dep | rs_m[bus.rd] | rd_m[bus.rd];
`endif
        dep = dep & valid_ret;
        dep[bus.alloc_idx] = 1'b0;
    end

    // Next-state of all matrices: retire first, then insert over it.
    always_comb begin
        rd_nxt    = rd_m;
`ifdef DEP_TRACKER_NAMEDEP_EN
        rs_nxt    = rs_m;
`endif
        wait_nxt  = wait_m;
        valid_nxt = valid_q;
        if (bus.ret_valid) begin
            valid_nxt[bus.ret_idx] = 1'b0;
            for (int r = 0; r < REGNUM; r++) begin
                rd_nxt[r][bus.ret_idx] = 1'b0;
`ifdef DEP_TRACKER_NAMEDEP_EN
                rs_nxt[r][bus.ret_idx] = 1'b0;
`endif
            end
            for (int w = 0; w < BS; w++)
                wait_nxt[w][bus.ret_idx] = 1'b0;
            wait_nxt[bus.ret_idx] = '0;
        end
        if (ins) begin
            for (int r = 0; r < REGNUM; r++) begin
                rd_nxt[r][bus.alloc_idx] = 1'b0;
`ifdef DEP_TRACKER_NAMEDEP_EN
                rs_nxt[r][bus.alloc_idx] = 1'b0;
`endif
            end
`ifdef DEP_TRACKER_NAMEDEP_EN
            for (int k = 0; k < NSRC; k++) begin
                if (bus.rs_use[k] && (bus.rs[k*RW +: RW] != '0))
                    rs_nxt[bus.rs[k*RW +: RW]][bus.alloc_idx] = 1'b1;
            end
`endif
            if (bus.rd_we && (bus.rd != '0))
                rd_nxt[bus.rd][bus.alloc_idx] = 1'b1;
            valid_nxt[bus.alloc_idx] = 1'b1;
            wait_nxt[bus.alloc_idx]  = dep;
        end
    end

    // Ready to issue: occupied and every producer it waited on has retired.
    always_comb begin
        issue_nxt = '0;
        for (int i = 0; i < BS; i++)
            issue_nxt[i] = valid_nxt[i] & ~(|wait_nxt[i]);
    end

    // State registers; reset wins over any same-cycle insert or retire.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < REGNUM; r++) begin
                rd_m[r] <= '0;
`ifdef DEP_TRACKER_NAMEDEP_EN
                rs_m[r] <= '0;
`endif
            end
            for (int w = 0; w < BS; w++)
                wait_m[w] <= '0;
            valid_q     <= '0;
            idt_q       <= '0;
            idt_valid_q <= 1'b0;
            issue_rdy_q <= '0;
        end else begin
            for (int r = 0; r < REGNUM; r++) begin
                rd_m[r] <= rd_nxt[r];
`ifdef DEP_TRACKER_NAMEDEP_EN
                rs_m[r] <= rs_nxt[r];
`endif
            end
            for (int w = 0; w < BS; w++)
                wait_m[w] <= wait_nxt[w];
            valid_q     <= valid_nxt;
            idt_valid_q <= ins;
            if (ins)
                idt_q <= dep;
            issue_rdy_q <= issue_nxt;
        end
    end
endmodule

// File: tb/tb_dep_tracker.sv
// Purpose: directed scoreboard bench for dep_tracker (default parameters).
// Latency: expects registered status one clock after each insert/retire.
// Backpressure: exercises refused inserts on occupied columns and same-cycle retire+reuse.
module tb_dep_tracker;
    localparam int REGNUM = 32;
    localparam int BS     = 16;
    localparam int NSRC   = 2;

    typedef struct {
        logic [15:0] idt;
        logic [15:0] ev;
        logic [15:0] ir;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    exp_t sb[$];

    dep_tracker_if #(.REGNUM(REGNUM), .BS(BS), .NSRC(NSRC)) bus ();

    dep_tracker #(.REGNUM(REGNUM), .BS(BS), .NSRC(NSRC)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every idt_valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.idt_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_idt_valid", 32'(bus.idt_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("idt", 32'(bus.idt), 32'(e.idt));
                chk("entry_valid_after_insert", 32'(bus.entry_valid), 32'(e.ev));
                chk("issue_rdy_after_insert", 32'(bus.issue_rdy), 32'(e.ir));
            end
        end
    end

    task automatic idle_inputs();
        bus.alloc_valid = 1'b0;
        bus.alloc_idx   = '0;
        bus.rs          = '0;
        bus.rs_use      = '0;
        bus.rd          = '0;
        bus.rd_we       = 1'b0;
        bus.ret_valid   = 1'b0;
        bus.ret_idx     = '0;
    endtask

    // One accepted insert (optionally with a retire in the same cycle).
    task automatic ins(input int idx, input int s0, input int s1, input int use_m,
                       input int rd, input int we, input int ret, input int ridx,
                       input logic [15:0] e_idt, input logic [15:0] e_ev, input logic [15:0] e_ir);
        exp_t e;
        bus.alloc_valid = 1'b1;
        bus.alloc_idx   = 4'(idx);
        bus.rs          = {5'(s1), 5'(s0)};
        bus.rs_use      = 2'(use_m);
        bus.rd          = 5'(rd);
        bus.rd_we       = (we != 0);
        bus.ret_valid   = (ret != 0);
        bus.ret_idx     = 4'(ridx);
        #1;
        chk("alloc_ready_on_insert", 32'(bus.alloc_ready), 32'd1);
        e.idt = e_idt; e.ev = e_ev; e.ir = e_ir;
        sb.push_back(e);
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic retire(input int idx);
        bus.ret_valid = 1'b1;
        bus.ret_idx   = 4'(idx);
        @(posedge clk); #1;
        idle_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] last_idt;
        logic [15:0] ir_named;
        total = 0;
        bad   = 0;
        idle_inputs();
        // Reset held with an insert pending: reset must win.
        rst = 1'b1;
        bus.alloc_valid = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        idle_inputs();
        chk("reset_idt", 32'(bus.idt), 32'd0);
        chk("reset_idt_valid", 32'(bus.idt_valid), 32'd0);
        chk("reset_entry_valid", 32'(bus.entry_valid), 32'd0);
        chk("reset_issue_rdy", 32'(bus.issue_rdy), 32'd0);
        for (int i = 0; i < BS; i++) begin
            bus.alloc_idx = 4'(i);
            #0.1;
            chk("reset_alloc_ready", 32'(bus.alloc_ready), 32'd1);
        end
        bus.alloc_idx = '0;

        // RAW chain: idx0 writes r5, idx1 reads r5.
        ins(0, 0, 0, 0, 5, 1, 0, 0, 16'h0000, 16'h0001, 16'h0001);
        ins(1, 5, 0, 1, 0, 0, 0, 0, 16'h0001, 16'h0003, 16'h0001);
        retire(0);
        chk("retire_issue_rdy", 32'(bus.issue_rdy), 32'h0002);
        chk("retire_entry_valid", 32'(bus.entry_valid), 32'h0002);
        chk("retire_idt_valid_low", 32'(bus.idt_valid), 32'd0);
        chk("retire_idt_held", 32'(bus.idt), 32'h0001);

        // Refused insert into an occupied column.
        ins(3, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h000A, 16'h000A);
        bus.alloc_valid = 1'b1;
        bus.alloc_idx   = 4'd3;
        bus.rs          = {5'd0, 5'd1};
        bus.rs_use      = 2'b01;
        bus.rd          = 5'd1;
        bus.rd_we       = 1'b1;
        #1;
        chk("occupied_alloc_ready", 32'(bus.alloc_ready), 32'd0);
        @(posedge clk); #1;
        idle_inputs();
        chk("refused_idt_valid", 32'(bus.idt_valid), 32'd0);
        chk("refused_entry_valid", 32'(bus.entry_valid), 32'h000A);
        chk("refused_issue_rdy", 32'(bus.issue_rdy), 32'h000A);
        chk("refused_idt_held", 32'(bus.idt), 32'h0000);

        // Producer retired in the same cycle as a consumer is inserted.
        ins(2, 0, 0, 0, 7, 1, 0, 0, 16'h0000, 16'h000E, 16'h000E);
        ins(4, 7, 7, 3, 0, 0, 1, 2, 16'h0000, 16'h001A, 16'h001A);

        // Retire and re-insert the same column in one cycle.
        ins(5, 0, 0, 0, 3, 1, 0, 0, 16'h0000, 16'h003A, 16'h003A);
        ins(1, 3, 0, 1, 0, 0, 1, 1, 16'h0020, 16'h003A, 16'h0038);

        // Register 0 is never tracked.
        ins(6, 0, 0, 0, 0, 1, 0, 0, 16'h0000, 16'h007A, 16'h0078);
        ins(7, 0, 0, 3, 0, 0, 0, 0, 16'h0000, 16'h00FA, 16'h00F8);

        // Name dependency (WAR) only when the macro is defined.
        ins(8, 9, 0, 1, 0, 0, 0, 0, 16'h0000, 16'h01FA, 16'h01F8);
`ifdef DEP_TRACKER_NAMEDEP_EN
        last_idt = 16'h0100;
        ir_named = 16'h01F8;
`else
        last_idt = 16'h0000;
        ir_named = 16'h03F8;
`endif
        ins(9, 0, 0, 0, 9, 1, 0, 0, last_idt, 16'h03FA, ir_named);
        retire(8);
        chk("war_release_issue_rdy", 32'(bus.issue_rdy), 32'h02F8);
        chk("war_release_entry_valid", 32'(bus.entry_valid), 32'h02FA);

        // Reset concurrent with an acceptable insert.
        bus.alloc_valid = 1'b1;
        bus.alloc_idx   = 4'd0;
        bus.rd          = 5'd4;
        bus.rd_we       = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        idle_inputs();
        chk("rst_ins_idt", 32'(bus.idt), 32'd0);
        chk("rst_ins_idt_valid", 32'(bus.idt_valid), 32'd0);
        chk("rst_ins_entry_valid", 32'(bus.entry_valid), 32'd0);
        chk("rst_ins_issue_rdy", 32'(bus.issue_rdy), 32'd0);
        @(posedge clk); #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
